// File: rtl/shot_scheduler_pkg.sv
// Shared game definitions: shot lifecycle encoding, screen geometry and
// counter widths used by the shot scheduler and the laser datapath.
package shot_scheduler_pkg;

    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;

    localparam int STEP_W = 4;
    localparam int COOL_W = 8;
    localparam int SHOT_W = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LAUNCH   = 2'd1,
        FLIGHT   = 2'd2,
        COOLDOWN = 2'd3
    } shot_state_t;

    function automatic logic [SHOT_W-1:0] sat_inc(input logic [SHOT_W-1:0] value);
        return (value == {SHOT_W{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/shot_scheduler_frame_ticker.sv
// Frame tick and laser motion-step pulse generation from the VGA scan position.
module frame_ticker
    import shot_scheduler_pkg::*;
#(
    parameter int SCREEN_WIDTH  = shot_scheduler_pkg::SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = shot_scheduler_pkg::SCREEN_HEIGHT,
    parameter int STEP_DIV      = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       game_run,
    input  logic [9:0] hPos,
    input  logic [9:0] vPos,
    output logic       ft,
    output logic       laser_enable
);

    localparam logic [9:0]        LAST_COL  = 10'(SCREEN_WIDTH - 1);
    localparam logic [9:0]        TICK_LINE = 10'(SCREEN_HEIGHT);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);

    logic              tick;
    logic [STEP_W-1:0] step_reg;
    logic              ft_reg;
    logic              enable_reg;

    // First line below the visible area, column 0: once per frame.
    assign tick = game_run && (hPos == 10'd0) && (hPos <= LAST_COL) && (vPos == TICK_LINE);

    always_ff @(posedge clk) begin
        if (reset || !game_run) begin
            step_reg   <= '0;
            ft_reg     <= 1'b0;
            enable_reg <= 1'b0;
        end else begin
            ft_reg     <= tick;
            enable_reg <= tick && (step_reg == STEP_LAST);
            if (tick) begin
                step_reg <= (step_reg == STEP_LAST) ? '0 : step_reg + 1'b1;
            end
        end
    end

    assign ft           = ft_reg;
    assign laser_enable = enable_reg;

endmodule

// File: rtl/shot_scheduler.sv
// Player shot lifecycle: clean launch request, one shot in flight, cooldown
// before re-arming, and the laser datapath enable/fire controls.
module shot_scheduler
    import shot_scheduler_pkg::*;
#(
    parameter int SCREEN_WIDTH    = shot_scheduler_pkg::SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT   = shot_scheduler_pkg::SCREEN_HEIGHT,
    parameter int STEP_DIV        = 1,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              game_run,
    input  logic              fire_btn,
    input  logic [9:0]        hPos,
    input  logic [9:0]        vPos,
    input  logic              laser_hit,
    input  logic [9:0]        laser_y,
    output logic              laser_enable,
    output logic              laser_fire,
    output logic              shot_active,
    output logic              cooldown_busy,
    output logic [SHOT_W-1:0] shots_fired
);

    localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(COOLDOWN_FRAMES);

    logic              ft;
    logic              btn_q;
    logic              press;
    logic              shot_end;
    shot_state_t       state_reg,  state_next;
    logic [COOL_W-1:0] cool_reg,   cool_next;
    logic [SHOT_W-1:0] shots_reg,  shots_next;
    logic              fire_reg,   fire_next;
    logic              active_reg, active_next;
    logic              busy_reg,   busy_next;

    frame_ticker #(
        .SCREEN_WIDTH  (SCREEN_WIDTH),
        .SCREEN_HEIGHT (SCREEN_HEIGHT),
        .STEP_DIV      (STEP_DIV)
    ) u_frame_ticker (
        .clk          (clk),
        .reset        (reset),
        .game_run     (game_run),
        .hPos         (hPos),
        .vPos         (vPos),
        .ft           (ft),
        .laser_enable (laser_enable)
    );

    // btn_q resets high so a button held through reset needs a fresh press.
    assign press    = fire_btn & ~btn_q;
    assign shot_end = laser_hit | (laser_enable & (laser_y == 10'd0));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            btn_q      <= 1'b1;
            cool_reg   <= '0;
            shots_reg  <= '0;
            fire_reg   <= 1'b0;
            active_reg <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            btn_q      <= fire_btn;
            cool_reg   <= cool_next;
            shots_reg  <= shots_next;
            fire_reg   <= fire_next;
            active_reg <= active_next;
            busy_reg   <= busy_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cool_next  = cool_reg;
        shots_next = shots_reg;
        if (!game_run) begin
            state_next = IDLE;
            cool_next  = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (press) begin
                        state_next = LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (laser_enable) begin
                        state_next = FLIGHT;
                        shots_next = sat_inc(shots_reg);
                    end
                end
                FLIGHT: begin
                    if (shot_end) begin
                        if (COOLDOWN_FRAMES == 0) begin
                            state_next = IDLE;
                        end else begin
                            state_next = COOLDOWN;
                            cool_next  = COOL_LOAD;
                        end
                    end
                end
                COOLDOWN: begin
                    // The tick that takes the count to zero ends the cooldown.
                    if (ft) begin
                        if (cool_reg <= 1) begin
                            state_next = IDLE;
                            cool_next  = '0;
                        end else begin
                            cool_next = cool_reg - 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Decoded from the next state so every output leaves a flop.
    always_comb begin
        fire_next   = (state_next == LAUNCH);
        active_next = (state_next == LAUNCH) || (state_next == FLIGHT);
        busy_next   = (state_next == COOLDOWN);
    end

    assign laser_fire    = fire_reg;
    assign shot_active   = active_reg;
    assign cooldown_busy = busy_reg;
    assign shots_fired   = shots_reg;

endmodule

// File: tb/tb_shot_scheduler.sv
// Scoreboard bench for shot_scheduler: a behavioural model predicts the
// outputs after every clock edge and a monitor compares them on the falling edge.
module tb_shot_scheduler;

    localparam int STEP_DIV  = 3;
    localparam int COOL      = 8;
    localparam int TICK_LINE = 480;

    localparam int P_IDLE   = 0;
    localparam int P_LAUNCH = 1;
    localparam int P_FLIGHT = 2;
    localparam int P_COOL   = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       game_run;
    logic       fire_btn;
    logic [9:0] hPos;
    logic [9:0] vPos;
    logic       laser_hit;
    logic [9:0] laser_y;
    logic       laser_enable;
    logic       laser_fire;
    logic       shot_active;
    logic       cooldown_busy;
    logic [7:0] shots_fired;

    typedef struct packed {
        logic       en;
        logic       fire;
        logic       active;
        logic       busy;
        logic [7:0] shots;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cycle_no    = 0;
    int   en_count    = 0;
    int   fire_count  = 0;
    int   scan_idx    = 0;

    shot_scheduler #(
        .SCREEN_WIDTH    (640),
        .SCREEN_HEIGHT   (480),
        .STEP_DIV        (STEP_DIV),
        .COOLDOWN_FRAMES (COOL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .game_run      (game_run),
        .fire_btn      (fire_btn),
        .hPos          (hPos),
        .vPos          (vPos),
        .laser_hit     (laser_hit),
        .laser_y       (laser_y),
        .laser_enable  (laser_enable),
        .laser_fire    (laser_fire),
        .shot_active   (shot_active),
        .cooldown_busy (cooldown_busy),
        .shots_fired   (shots_fired)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cycle_no, got, want);
        end
    endtask

    // Compressed scan: 8 cycles per frame, frame tick position once per frame.
    task automatic cycle();
        @(posedge clk);
        #1;
        cycle_no++;
        scan_idx = (scan_idx + 1) % 8;
        hPos = 10'(scan_idx % 2);
        vPos = 10'(478 + scan_idx / 2);
    endtask

    task automatic wait_for(input int what);
        int  budget;
        bit  done;
        budget = 300;
        done   = 1'b0;
        while (!done && budget > 0) begin
            case (what)
                0:       done = shot_active && !laser_fire;
                1:       done = !shot_active && !cooldown_busy;
                default: done = cooldown_busy;
            endcase
            if (!done) begin
                cycle();
                budget--;
            end
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL wait_%0d: condition not reached within 300 cycles", what);
        end
    endtask

    task automatic press();
        fire_btn = 1'b0;
        cycle();
        fire_btn = 1'b1;
        cycle();
    endtask

    // Reference model: shot lifecycle from the behavioural rules.
    initial begin
        int   phase;
        int   ticks_run;
        int   cool_left;
        int   shots;
        bit   prev_btn;
        bit   cur_en;
        bit   cur_ft;
        bit   tick;
        bit   new_en;
        bit   pressed;
        exp_t e;
        phase = P_IDLE; ticks_run = 0; cool_left = 0; shots = 0;
        prev_btn = 1'b1; cur_en = 1'b0; cur_ft = 1'b0;
        forever begin
            @(posedge clk);
            if (reset) begin
                phase = P_IDLE; ticks_run = 0; cool_left = 0; shots = 0;
                prev_btn = 1'b1; cur_en = 1'b0; cur_ft = 1'b0;
            end else begin
                tick     = game_run && (hPos == 0) && (vPos == TICK_LINE);
                pressed  = fire_btn && !prev_btn;
                prev_btn = fire_btn;
                if (!game_run) begin
                    phase     = P_IDLE;
                    cool_left = 0;
                    ticks_run = 0;
                end else if (phase == P_IDLE) begin
                    if (pressed) phase = P_LAUNCH;
                end else if (phase == P_LAUNCH) begin
                    if (cur_en) begin
                        phase = P_FLIGHT;
                        if (shots < 255) shots++;
                    end
                end else if (phase == P_FLIGHT) begin
                    if (laser_hit || (cur_en && laser_y == 0)) begin
                        if (COOL == 0) phase = P_IDLE;
                        else begin
                            phase     = P_COOL;
                            cool_left = COOL;
                        end
                    end
                end else begin
                    if (cur_ft) begin
                        cool_left--;
                        if (cool_left == 0) phase = P_IDLE;
                    end
                end
                new_en = tick && (ticks_run % STEP_DIV == STEP_DIV - 1);
                if (tick) ticks_run++;
                cur_en = new_en;
                cur_ft = tick;
            end
            e.en     = cur_en;
            e.fire   = (phase == P_LAUNCH);
            e.active = (phase == P_LAUNCH) || (phase == P_FLIGHT);
            e.busy   = (phase == P_COOL);
            e.shots  = 8'(shots);
            exp_q.push_back(e);
        end
    end

    // Monitor: compares DUT outputs against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (laser_enable === 1'b1) en_count++;
            if (laser_fire === 1'b1) fire_count++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("laser_enable",  32'(laser_enable),  32'(e.en));
                check("laser_fire",    32'(laser_fire),    32'(e.fire));
                check("shot_active",   32'(shot_active),   32'(e.active));
                check("cooldown_busy", 32'(cooldown_busy), 32'(e.busy));
                check("shots_fired",   32'(shots_fired),   32'(e.shots));
            end
        end
    end

    initial begin
        reset = 1'b1; game_run = 1'b1; fire_btn = 1'b1; laser_hit = 1'b0;
        laser_y = 10'd100; hPos = 10'd0; vPos = 10'd478;
        repeat (3) cycle();
        reset = 1'b0;

        // Button held through reset must not fire.
        fire_count = 0;
        repeat (24) cycle();
        check("held_btn_no_fire", 32'(fire_count), 32'd0);

        press();
        check("press_latency", 32'(laser_fire), 32'd1);
        wait_for(0);
        check("first_shot_count", 32'(shots_fired), 32'd1);

        // Hit ends the flight; a press during cooldown is discarded.
        laser_hit = 1'b1;
        cycle();
        laser_hit = 1'b0;
        check("hit_to_cooldown", 32'(cooldown_busy), 32'd1);
        press();
        wait_for(1);
        repeat (4) cycle();
        check("cooldown_press_ignored", 32'(shot_active), 32'd0);
        press();
        check("relaunch_after_cooldown", 32'(laser_fire), 32'd1);

        // Hit and laser_y==0 on the same motion step.
        wait_for(0);
        for (int i = 0; i < 100 && laser_enable !== 1'b1; i++) cycle();
        check("enable_seen_in_flight", 32'(laser_enable), 32'd1);
        laser_hit = 1'b1;
        laser_y   = 10'd0;
        cycle();
        laser_hit = 1'b0;
        laser_y   = 10'd100;
        check("double_end_cooldown", 32'(cooldown_busy), 32'd1);
        wait_for(1);

        // Nine frames of scan give three motion steps.
        en_count = 0;
        repeat (72) cycle();
        check("enable_per_9_frames", 32'(en_count), 32'd3);

        // game_run dropped mid-flight.
        press();
        wait_for(0);
        game_run = 1'b0;
        cycle();
        check("run_low_idle", 32'(shot_active), 32'd0);
        en_count = 0;
        repeat (16) cycle();
        check("run_low_no_enable", 32'(en_count), 32'd0);
        game_run = 1'b1;
        press();
        check("run_restored_launch", 32'(laser_fire), 32'd1);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) fire_btn = ~fire_btn;
            laser_hit = ($urandom_range(0, 39) == 0);
            laser_y   = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom_range(1, 479));
            if (game_run && $urandom_range(0, 299) == 0) game_run = 1'b0;
            else if (!game_run && $urandom_range(0, 7) == 0) game_run = 1'b1;
            cycle();
        end

        // Saturation of the shot counter.
        game_run = 1'b1; laser_hit = 1'b0; laser_y = 10'd100; fire_btn = 1'b1;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int n = 0; n < 300; n++) begin
            press();
            wait_for(0);
            laser_hit = 1'b1;
            cycle();
            laser_hit = 1'b0;
            wait_for(1);
        end
        check("shots_saturated", 32'(shots_fired), 32'd255);

        // Reset mid-flight.
        press();
        wait_for(0);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("reset_active", 32'(shot_active), 32'd0);
        check("reset_shots", 32'(shots_fired), 32'd0);
        repeat (4) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/shot_scheduler.md
# shot_scheduler

Sequences the player laser datapath. Derives the per-frame motion tick from the VGA scan position, converts the raw fire button into a single clean launch request, tracks the shot lifecycle (launch, flight, cooldown) and drives the laser datapath's `enable` and `fire` inputs. It sits between the input/VGA timing logic and the laser datapath, and enforces one shot in flight with a minimum re-fire interval.

## Interface
- `SCREEN_WIDTH`, default 640: visible width; hPos range check only.
- `SCREEN_HEIGHT`, default 480: visible height; frame tick line.
- `STEP_DIV`, default 1: frame ticks per laser motion step (1..15).
- `COOLDOWN_FRAMES`, default 8: frame ticks between shot end and re-arm (0..255).

Ports:
- `clk` input 1: single clock, pixel clock domain.
- `reset` input 1: synchronous, active-high; this is the only reset.
- `game_run` input 1: high while play is active; low freezes the block.
- `fire_btn` input 1: fire button level, already synchronous to `clk`.
- `hPos` input 10: current scan column.
- `vPos` input 10: current scan line.
- `laser_hit` input 1: laser destroyed an alien (same signal the datapath sees as killingAlien).
- `laser_y` input 10: current laser vertical position from the datapath.
- `laser_enable` output 1: one-cycle motion-step pulse to the datapath.
- `laser_fire` output 1: launch request to the datapath.
- `shot_active` output 1: high in LAUNCH or FLIGHT.
- `cooldown_busy` output 1: high in COOLDOWN.
- `shots_fired` output 8: saturating count of launched shots.

## Operation
- Frame tick `ft`: one cycle when `hPos==0 && vPos==SCREEN_HEIGHT && game_run`.
- Step counter, 4 bits: counts `ft`. `laser_enable` pulses on the `ft` where the counter equals `STEP_DIV-1`; the counter then wraps to 0.
- Button edge: `btn_q` register, reset value 1. A press is `fire_btn & ~btn_q`. A button held through reset does not fire until it is released and pressed again.
- FSM states and transitions:
  - IDLE: a press moves to LAUNCH. Presses in any other state are discarded, not queued.
  - LAUNCH: `laser_fire=1`. Hold until a cycle with `laser_enable=1`, then go to FLIGHT and increment `shots_fired`, saturating at 255.
  - FLIGHT: `laser_hit` in any cycle goes to COOLDOWN. A `laser_enable` cycle with `laser_y==0` also goes to COOLDOWN. Both in the same cycle give a single transition.
  - COOLDOWN: the counter loads `COOLDOWN_FRAMES` on entry and decrements on each `ft`. At 0 the FSM goes to IDLE. With `COOLDOWN_FRAMES==0`, FLIGHT goes directly to IDLE.
- `game_run` low:
  - `ft` and `laser_enable` are suppressed.
  - FSM is forced to IDLE; step and cooldown counters clear.
  - `laser_fire` is 0; `shots_fired` is held.

## Timing
- All outputs are registered; reset value of every output is 0.
- Press to `laser_fire` high: 1 cycle after the edge is seen.
- `laser_fire` to drop: it drops the cycle after the `laser_enable` pulse it coincided with.
- `laser_enable` is exactly 1 cycle wide, once per `STEP_DIV` frames.
- Cooldown lasts exactly `COOLDOWN_FRAMES` frame ticks after the shot ends.
- Reset mid-flight: next cycle is IDLE with all outputs 0. The datapath is reset by the same `reset`.

## Structure
- Shared game package holds the FSM state encoding (IDLE, LAUNCH, FLIGHT, COOLDOWN, 2 bits) and the screen constants `SCREEN_WIDTH`/`SCREEN_HEIGHT`, reused by the laser datapath.
- One sub-module, `frame_ticker`: generates `ft` and `laser_enable` from hPos/vPos/`game_run` with the step divider. The FSM, edge detect and counters stay in the top level.

## Test plan
- Reset with `fire_btn=1` held, then 3 frames: `laser_fire` stays 0. Release, then press: `laser_fire` goes high 1 cycle later and `shots_fired=1` after the next `laser_enable`.
- `STEP_DIV=3`, 9 frames of scan: exactly 3 `laser_enable` pulses, each 1 cycle wide, at `vPos=480`, `hPos=0`.
- Flight, then `laser_hit` pulse: `cooldown_busy` high for 8 frame ticks, then IDLE. A press during cooldown is ignored; a press after cooldown launches.
- FLIGHT with `laser_y` stepping to 0 while `laser_hit=1` on the same `laser_enable` cycle: a single COOLDOWN entry, counter loaded with 8.
- `game_run` dropped mid-FLIGHT: next cycle IDLE, no `laser_enable`, `shots_fired` unchanged. Restore `game_run`: a new press launches normally.
- 300 press/flight/cooldown cycles: `shots_fired` saturates at 255.
